// File: rtl/hdmi_tx_pkg.sv
// Shared types and constants for the HDMI TX video source: 720p60 timing defaults,
// lock-FSM state encoding, the RGB pixel struct and the test-pattern colour bars.
package hdmi_tx_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] COLOUR_BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/hdmi_tx_video_gen_timing_cnt.sv
// Raster position counters for the video source; decodes active area, hsync/vsync
// windows and the frame's first pixel from the registered counters.
module video_timing_cnt
    import hdmi_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clkin,
    input  logic          rstin_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          first_pixel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clkin) begin
        if (!rstin_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs          = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    // vsync spans whole lines, switching at h_cnt = 0 rather than at the hsync edge
    assign vs          = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
    assign first_pixel = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/hdmi_tx_video_gen.sv
// Pixel-clock video source for the TMDS encoders: raster timing plus an SOF-locked
// RGB stream. Define HDMI_TX_TPG_EN to add the tpg_en input and colour-bar generator.
//
// state  | meaning
// SEARCH | not frame-aligned: drop non-SOF beats, hold SOF until raster origin
// LOCKED | stream aligned to raster: one beat per active slot
module hdmi_tx_video_gen
    import hdmi_tx_pkg::*;
#(
    parameter int          H_ACTIVE      = DEF_H_ACTIVE,
    parameter int          H_FP          = DEF_H_FP,
    parameter int          H_SYNC        = DEF_H_SYNC,
    parameter int          H_BP          = DEF_H_BP,
    parameter int          V_ACTIVE      = DEF_V_ACTIVE,
    parameter int          V_FP          = DEF_V_FP,
    parameter int          V_SYNC        = DEF_V_SYNC,
    parameter int          V_BP          = DEF_V_BP,
    parameter logic        HS_POL        = 1'b1,
    parameter logic        VS_POL        = 1'b1,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
    input  logic        clkin,
    input  logic        rstin_n,
`ifdef HDMI_TX_TPG_EN
    input  logic        tpg_en,
`endif
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tuser,
    output logic        s_tready,
    output logic        vid_de,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic [7:0]  vid_r,
    output logic [7:0]  vid_g,
    output logic [7:0]  vid_b,
    output logic        frame_start,
    output logic        underflow
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    localparam logic [0:0] ST_SEARCH = SEARCH;
    localparam logic [0:0] ST_LOCKED = LOCKED;

    logic          active, hs, vs, first_pixel;
    logic [0:0]    state, state_nxt;
    logic          ready, take, uf_nxt;
    rgb_t          pix_nxt;

`ifdef HDMI_TX_TPG_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] bar_raw;
    logic [2:0]    bar_idx;
`endif

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW (HW), .VW (VW)
    ) u_timing (
        .clkin       (clkin),
        .rstin_n     (rstin_n),
`ifdef HDMI_TX_TPG_EN
        .h_cnt       (h_cnt),
`else
        .h_cnt       (),
`endif
        .v_cnt       (),
        .active      (active),
        .hs          (hs),
        .vs          (vs),
        .first_pixel (first_pixel)
    );

`ifdef HDMI_TX_TPG_EN
    // last bar absorbs any remainder of H_ACTIVE/8
    assign bar_raw = h_cnt / HW'(BAR_W);
    assign bar_idx = (bar_raw > HW'(7)) ? 3'd7 : bar_raw[2:0];
`endif

    always_comb begin
        state_nxt = state;
        uf_nxt    = 1'b0;
        pix_nxt   = '0;
        if (state == ST_LOCKED)
            ready = active & ~(s_tuser & ~first_pixel);
        else
            ready = ~s_tuser | first_pixel;
        // in SEARCH only the SOF beat at the raster origin carries a pixel
        take = s_tvalid & ready & ((state == ST_LOCKED) | s_tuser);
        if (active) begin
            pix_nxt = take ? rgb_t'(s_tdata) : rgb_t'(UNDERFLOW_RGB);
            if (state == ST_LOCKED && !take) begin
                uf_nxt    = 1'b1;
                state_nxt = ST_SEARCH;
            end
        end
        if (state == ST_SEARCH && take)
            state_nxt = ST_LOCKED;
`ifdef HDMI_TX_TPG_EN
        if (tpg_en) begin
            ready     = 1'b0;
            uf_nxt    = 1'b0;
            state_nxt = ST_SEARCH;
            pix_nxt   = active ? rgb_t'(COLOUR_BARS[bar_idx]) : '0;
        end
`endif
    end

    assign s_tready = rstin_n & ready;

    always_ff @(posedge clkin) begin
        if (!rstin_n) begin
            state       <= ST_SEARCH;
            vid_de      <= 1'b0;
            vid_hs      <= ~HS_POL;
            vid_vs      <= ~VS_POL;
            vid_r       <= '0;
            vid_g       <= '0;
            vid_b       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_nxt;
            vid_de      <= active;
            vid_hs      <= HS_POL ? hs : ~hs;
            vid_vs      <= VS_POL ? vs : ~vs;
            vid_r       <= pix_nxt.r;
            vid_g       <= pix_nxt.g;
            vid_b       <= pix_nxt.b;
            frame_start <= first_pixel;
            underflow   <= uf_nxt;
        end
    end

endmodule

// File: tb/tb_hdmi_tx_video_gen.sv
// Randomized stream bench for hdmi_tx_video_gen on a 14x7 raster, checked cycle by
// cycle against a frame-position reference model of the timing and SOF-lock rules.
module tb_hdmi_tx_video_gen;

    localparam int H_ACT = 8, H_FP = 2, H_SY = 2, H_BP = 2;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;
    localparam logic        HS_P = 1'b1;
    localparam logic        VS_P = 1'b0;
    localparam logic [23:0] UF_RGB = 24'h123456;
    localparam int N_CYC = 5000;

    logic        clkin = 1'b0;
    logic        rstin_n = 1'b0;
    logic [23:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_tready;
    logic        vid_de, vid_hs, vid_vs, frame_start, underflow;
    logic [7:0]  vid_r, vid_g, vid_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clkin = ~clkin;

    hdmi_tx_video_gen #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .HS_POL (HS_P), .VS_POL (VS_P), .UNDERFLOW_RGB (UF_RGB)
    ) dut (
        .clkin       (clkin),
        .rstin_n     (rstin_n),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tuser     (s_tuser),
        .s_tready    (s_tready),
        .vid_de      (vid_de),
        .vid_hs      (vid_hs),
        .vid_vs      (vid_vs),
        .vid_r       (vid_r),
        .vid_g       (vid_g),
        .vid_b       (vid_b),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // expected registered outputs, starting from reset values
    logic        e_de = 1'b0, e_hs = ~HS_P, e_vs = ~VS_P, e_fs = 1'b0, e_uf = 1'b0;
    logic [23:0] e_rgb = '0;
    int          m_pos = 0;
    bit          m_locked = 0;

    // source stream: 32-beat frames, SOF on beat 0
    int          src_idx = 0;
    logic [23:0] src_data = '0;

    initial begin
        int h, v;
        bit act, first, e_ready, use_px, hs_w, vs_w, advance;
        int phase_valid;
        @(posedge clkin);
        advance = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clkin);
            check_val("vid_de", {31'd0, vid_de}, {31'd0, e_de});
            check_val("vid_hs", {31'd0, vid_hs}, {31'd0, e_hs});
            check_val("vid_vs", {31'd0, vid_vs}, {31'd0, e_vs});
            check_val("vid_rgb", {8'd0, vid_r, vid_g, vid_b}, {8'd0, e_rgb});
            check_val("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
            check_val("underflow", {31'd0, underflow}, {31'd0, e_uf});

            if (advance) begin
                src_idx  = (src_idx + 1) % (H_ACT * V_ACT);
                src_data = 24'($urandom);
            end
            // phases: reset, idle, continuous stream, then randomized gaps/jumps/resets
            rstin_n = !(cyc < 3 || cyc == 820 || (cyc > 900 && $urandom_range(0, 599) == 0));
            if (cyc < 250) phase_valid = 0;
            else if (cyc < 700) phase_valid = 100;
            else phase_valid = 93;
            if (cyc > 700 && $urandom_range(0, 299) == 0) src_idx = 0;
            if (cyc > 700 && $urandom_range(0, 299) == 0) src_idx = $urandom_range(1, 31);
            s_tvalid = ($urandom_range(1, 100) <= phase_valid);
            s_tuser  = (src_idx == 0);
            s_tdata  = src_data;
            #1;

            if (!rstin_n) begin
                e_ready = 0;
                e_de = 0; e_hs = ~HS_P; e_vs = ~VS_P; e_rgb = '0; e_fs = 0; e_uf = 0;
                m_pos = 0;
                m_locked = 0;
            end else begin
                h     = m_pos % H_TOT;
                v     = m_pos / H_TOT;
                act   = (h < H_ACT) && (v < V_ACT);
                first = (m_pos == 0);
                hs_w  = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY);
                vs_w  = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY);
                if (m_locked) e_ready = act && !(s_tuser && !first);
                else          e_ready = !s_tuser || first;
                // a handshake yields a displayed pixel when locked, or when it is the SOF that locks
                use_px = s_tvalid && e_ready && (m_locked || (first && s_tuser));
                e_de  = act;
                e_hs  = HS_P ? hs_w : ~hs_w;
                e_vs  = VS_P ? vs_w : ~vs_w;
                e_rgb = !act ? 24'h0 : (use_px ? s_tdata : UF_RGB);
                e_fs  = first;
                e_uf  = m_locked && act && !use_px;
                if (m_locked && act && !use_px) m_locked = 0;
                else if (!m_locked && use_px)   m_locked = 1;
                m_pos = (m_pos + 1) % F_TOT;
            end
            check_val("s_tready", {31'd0, s_tready}, {31'd0, e_ready});
            advance = s_tvalid && s_tready;
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
